// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined word selector.
// Holds the skid-buffer state encoding and a clog2 helper.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer: M drives the outputs, S absorbs one stall.
// in_ready is registered so out_ready never reaches it combinationally.
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] m_q, m_d;
    logic [W-1:0] s_q, s_d;
    logic         ready_q;
    logic         push, pop;

    assign push      = in_valid & ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_data  = m_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    m_d     = in_data;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    m_d = in_data;
                end else if (push) begin
                    state_d = ST_TWO;
                    s_d     = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // ready_q is low here, so only a pop can happen
                if (pop) begin
                    state_d = ST_ONE;
                    m_d     = s_q;
                    s_d     = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            ready_q <= (state_d != ST_TWO);
        end
    end

endmodule

// File: rtl/mux_pipe_sel.sv
// N:1 word selector feeding a registered valid/ready skid buffer.
// Out-of-range selects forward zero and raise a sticky error flag.
module mux_pipe_sel
    import mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_INPUTS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err,
    input  logic                      err_clr
);

    localparam int BW = WIDTH + SEL_W;

    logic [WIDTH-1:0] word;
    logic             hit;
    logic             accept;
    logic [BW-1:0]    buf_out;
    logic             sel_err_q;

    // A select with no matching word leaves hit low and word zero
    always_comb begin
        word = '0;
        hit  = 1'b0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (in_sel == SEL_W'(k)) begin
                word = in_data[k*WIDTH +: WIDTH];
                hit  = 1'b1;
            end
        end
    end

    assign accept = in_valid & in_ready;

    mux_skid_buf #(
        .W(BW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_data  ({in_sel, word}),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (buf_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_sel  = buf_out[BW-1:WIDTH];
    assign out_data = buf_out[WIDTH-1:0];
    assign sel_err  = sel_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (accept && !hit) begin
            sel_err_q <= 1'b1;
        end else if (err_clr) begin
            sel_err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Directed and randomized checks of mux_pipe_sel across three configurations.
// Expected values come from constants and a queue-based FIFO model.
module tb_mux_pipe_sel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // A: WIDTH=32, N_INPUTS=8
    logic [255:0] a_in_data = '0;
    logic [2:0]   a_in_sel = '0;
    logic         a_in_valid = 1'b0, a_in_ready;
    logic [31:0]  a_out_data;
    logic [2:0]   a_out_sel;
    logic         a_out_valid, a_out_ready = 1'b0;
    logic         a_sel_err, a_err_clr = 1'b0;

    // B: WIDTH=32, N_INPUTS=5
    logic [159:0] b_in_data = '0;
    logic [2:0]   b_in_sel = '0;
    logic         b_in_valid = 1'b0, b_in_ready;
    logic [31:0]  b_out_data;
    logic [2:0]   b_out_sel;
    logic         b_out_valid, b_out_ready = 1'b0;
    logic         b_sel_err, b_err_clr = 1'b0;

    // C: WIDTH=16, N_INPUTS=3
    logic [47:0]  c_in_data = '0;
    logic [1:0]   c_in_sel = '0;
    logic         c_in_valid = 1'b0, c_in_ready;
    logic [15:0]  c_out_data;
    logic [1:0]   c_out_sel;
    logic         c_out_valid, c_out_ready = 1'b0;
    logic         c_sel_err, c_err_clr = 1'b0;

    mux_pipe_sel #(.WIDTH(32), .N_INPUTS(8), .SEL_W(3)) u_a (
        .clk(clk), .reset(rst),
        .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_sel(a_out_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sel_err(a_sel_err), .err_clr(a_err_clr)
    );

    mux_pipe_sel #(.WIDTH(32), .N_INPUTS(5), .SEL_W(3)) u_b (
        .clk(clk), .reset(rst),
        .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_sel(b_out_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sel_err(b_sel_err), .err_clr(b_err_clr)
    );

    mux_pipe_sel #(.WIDTH(16), .N_INPUTS(3), .SEL_W(2)) u_c (
        .clk(clk), .reset(rst),
        .in_data(c_in_data), .in_sel(c_in_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_sel(c_out_sel),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .sel_err(c_sel_err), .err_clr(c_err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Selected slot gets val, the rest get a recognisable filler
    function automatic logic [255:0] fill_a(input int sel, input logic [31:0] val);
        logic [255:0] r;
        for (int j = 0; j < 8; j++)
            r[j*32 +: 32] = (j == sel) ? val : 32'hDEAD_0000 + 32'(j);
        return r;
    endfunction

    logic [17:0] q[$];
    bit          push, pop, hold, err_exp;
    logic [1:0]  s;
    logic [15:0] w, held;

    initial begin
        // 1. reset and idle
        #2;
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_a_sel", a_out_sel, 0);
        chk("rst_a_err", a_sel_err, 0);
        chk("rst_a_ready", a_in_ready, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rel_a_ready", a_in_ready, 1);
        chk("rel_b_ready", b_in_ready, 1);
        chk("rel_c_ready", c_in_ready, 1);
        chk("rel_a_valid", a_out_valid, 0);

        // 2. full-rate streaming
        a_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 3'(k % 8);
            a_in_data  = fill_a(k % 8, 32'h1000_0000 + 32'(k));
            step();
            chk("strm_valid", a_out_valid, 1);
            chk("strm_data", a_out_data, 32'h1000_0000 + 32'(k));
            chk("strm_sel", a_out_sel, 64'(k % 8));
            chk("strm_ready", a_in_ready, 1);
        end
        a_in_valid = 1'b0;
        a_in_sel   = 'x;
        a_in_data  = 'x;
        step();
        chk("strm_drain", a_out_valid, 0);

        // 3. backpressure
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 3'd2;
        a_in_data   = fill_a(2, 32'hA000_0002);
        step();
        chk("bp1_data", a_out_data, 32'hA000_0002);
        chk("bp1_ready", a_in_ready, 1);
        a_in_sel  = 3'd5;
        a_in_data = fill_a(5, 32'hA000_0005);
        step();
        chk("bp2_data", a_out_data, 32'hA000_0002);
        chk("bp2_sel", a_out_sel, 2);
        chk("bp2_ready", a_in_ready, 0);
        a_in_sel  = 3'd7;
        a_in_data = fill_a(7, 32'hA000_0007);
        step();
        chk("bp3_data", a_out_data, 32'hA000_0002);
        chk("bp3_ready", a_in_ready, 0);
        a_out_ready = 1'b1;
        step();
        chk("rel1_data", a_out_data, 32'hA000_0005);
        chk("rel1_sel", a_out_sel, 5);
        chk("rel1_ready", a_in_ready, 1);
        step();
        chk("rel2_data", a_out_data, 32'hA000_0007);
        chk("rel2_sel", a_out_sel, 7);
        chk("rel2_valid", a_out_valid, 1);
        a_in_valid = 1'b0;
        step();
        chk("rel3_valid", a_out_valid, 0);

        // 5. reset while both entries full
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 3'd1;
        a_in_data   = fill_a(1, 32'hC000_0001);
        step();
        a_in_sel  = 3'd3;
        a_in_data = fill_a(3, 32'hC000_0003);
        step();
        a_in_valid = 1'b0;
        chk("two_ready", a_in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", a_out_valid, 0);
        chk("arst_data", a_out_data, 0);
        chk("arst_sel", a_out_sel, 0);
        chk("arst_ready", a_in_ready, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_ready", a_in_ready, 1);
        chk("post_valid", a_out_valid, 0);
        a_out_ready = 1'b1;
        step();
        chk("post_valid2", a_out_valid, 0);

        // 4. out-of-range selects on N_INPUTS=5
        for (int j = 0; j < 5; j++)
            b_in_data[j*32 +: 32] = 32'hB000_0000 + 32'(j);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_sel    = 3'd6;
        step();
        chk("oor_data", b_out_data, 0);
        chk("oor_sel", b_out_sel, 6);
        chk("oor_err", b_sel_err, 1);
        b_in_sel = 3'd4;
        step();
        chk("max_data", b_out_data, 32'hB000_0004);
        chk("max_err", b_sel_err, 1);
        b_in_sel  = 3'd5;
        b_err_clr = 1'b1;
        step();
        chk("clrset_err", b_sel_err, 1);
        chk("clrset_data", b_out_data, 0);
        chk("clrset_sel", b_out_sel, 5);
        b_in_valid = 1'b0;
        step();
        chk("clr_err", b_sel_err, 0);
        chk("clr_valid", b_out_valid, 0);
        b_err_clr  = 1'b0;
        b_in_valid = 1'b1;
        b_in_sel   = 3'd0;
        step();
        chk("ok_data", b_out_data, 32'hB000_0000);
        chk("ok_err", b_sel_err, 0);
        b_in_valid = 1'b0;

        // 6. random traffic against a FIFO model of depth two
        err_exp = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_out_ready = ($urandom_range(0, 4) > 1);
            c_err_clr   = ($urandom_range(0, 15) == 0);
            s           = 2'($urandom_range(0, 3));
            c_in_data   = {16'($urandom), 32'($urandom)};
            c_in_sel    = c_in_valid ? s : 2'bxx;
            pop  = (q.size() > 0) && c_out_ready;
            push = c_in_valid && (q.size() < 2);
            hold = (q.size() > 0) && !c_out_ready;
            if (hold) held = q[0][15:0];
            w = (s < 3) ? 16'(c_in_data >> (int'(s) * 16)) : 16'h0;
            step();
            if (pop) void'(q.pop_front());
            if (push) q.push_back({s, w});
            if (push && s >= 2'd3) err_exp = 1'b1;
            else if (c_err_clr) err_exp = 1'b0;
            chk("rnd_ready", c_in_ready, 64'(q.size() < 2));
            chk("rnd_valid", c_out_valid, 64'(q.size() > 0));
            chk("rnd_err", c_sel_err, 64'(err_exp));
            if (q.size() > 0) begin
                chk("rnd_data", c_out_data, q[0][15:0]);
                chk("rnd_sel", c_out_sel, q[0][17:16]);
            end
            if (hold) chk("rnd_hold", c_out_data, held);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
